// File: rtl/gray_step_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_step_tracker_if
// Description : Sample/observation bus of the Gray step tracker. The producer
//               side drives the Gray samples and the error clear; the tracker
//               side returns the decoded value, step statistics and errors.
// Revision    : 1.0 - initial release
// ============================================================================
interface gray_step_tracker_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) ();
  logic             valid_in;
  logic [WIDTH-1:0] gray_in;
  logic             clr_err;
  logic [WIDTH-1:0] bin_out;
  logic             dir_up;
  logic [CNT_W-1:0] step_cnt;
  logic             wrap;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  // Producer / observer side
  modport master (
    output valid_in, gray_in, clr_err,
    input  bin_out, dir_up, step_cnt, wrap, err, err_cnt
  );

  // Tracker side
  modport slave (
    input  valid_in, gray_in, clr_err,
    output bin_out, dir_up, step_cnt, wrap, err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/gray_step_tracker.sv
`default_nettype none
// ============================================================================
// Module      : gray_step_tracker
// Description : Samples a Gray up/down counter, converts each sample to binary
//               and verifies that it moved by exactly +/-1 (mod 2^WIDTH).
//               Reports value, direction, legal-step count, wrap pulse and a
//               sticky error flag with an illegal-transition count.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_step_tracker #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  gray_step_tracker_if.slave bus
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_TRACK = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIDTH-1:0] BIN_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] BIN_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state, state_next;
  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] prev_gray, prev_gray_next;
  logic [WIDTH-1:0] bin_q, bin_next;
  logic             dir_q, dir_next;
  logic [CNT_W-1:0] step_q, step_next;
  logic             wrap_q, wrap_next;
  logic             err_q, err_next;
  logic [CNT_W-1:0] errc_q, errc_next;
  logic             illegal;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_conv
      assign bin_new[i] = ^bus.gray_in[WIDTH-1:i];
    end
  endgenerate

  // State register: IDLE until the first valid sample, then TRACK
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: any valid sample moves IDLE into TRACK; TRACK is held
  always_comb begin
    state_next = state;
    if (state == ST_IDLE && bus.valid_in) begin
      state_next = ST_TRACK;
    end
  end

  // Output/datapath next values: step classification, counters and clear
  always_comb begin
    prev_gray_next = prev_gray;
    bin_next       = bin_q;
    dir_next       = dir_q;
    step_next      = step_q;
    wrap_next      = 1'b0;
    err_next       = err_q;
    errc_next      = errc_q;
    illegal        = 1'b0;

    if (bus.valid_in) begin
      if (state == ST_IDLE) begin
        prev_gray_next = bus.gray_in;
        bin_next       = bin_new;
      end else if (bus.gray_in != prev_gray) begin
        // Non-stall sample in TRACK: always resync to the new value
        prev_gray_next = bus.gray_in;
        bin_next       = bin_new;
        if (bin_new == bin_q + BIN_ONE) begin
          dir_next  = 1'b1;
          step_next = (step_q == CNT_MAX) ? step_q : step_q + CNT_ONE;
          wrap_next = (bin_q == BIN_MAX);
        end else if (bin_new == bin_q - BIN_ONE) begin
          dir_next  = 1'b0;
          step_next = (step_q == CNT_MAX) ? step_q : step_q + CNT_ONE;
          wrap_next = (bin_q == BIN_ZERO);
        end else begin
          illegal = 1'b1;
        end
      end
    end

    // A fresh illegal step overrides a simultaneous clear
    if (bus.clr_err) begin
      err_next  = illegal;
      errc_next = illegal ? CNT_ONE : '0;
    end else if (illegal) begin
      err_next  = 1'b1;
      errc_next = (errc_q == CNT_MAX) ? errc_q : errc_q + CNT_ONE;
    end
  end

  // Registered outputs and last accepted sample
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_gray <= '0;
      bin_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= '0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      errc_q    <= '0;
    end else begin
      prev_gray <= prev_gray_next;
      bin_q     <= bin_next;
      dir_q     <= dir_next;
      step_q    <= step_next;
      wrap_q    <= wrap_next;
      err_q     <= err_next;
      errc_q    <= errc_next;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.dir_up   = dir_q;
  assign bus.step_cnt = step_q;
  assign bus.wrap     = wrap_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = errc_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_step_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_step_tracker
// Description : Directed, table-driven bench for gray_step_tracker. Drives an
//               8-bit-counter instance and a 2-bit-counter instance with the
//               same stimulus and compares against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_step_tracker;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  gray_step_tracker_if #(.WIDTH(3), .CNT_W(8)) if_big ();
  gray_step_tracker_if #(.WIDTH(3), .CNT_W(2)) if_small ();

  gray_step_tracker #(.WIDTH(3), .CNT_W(8)) dut_big (
    .clk   (clk),
    .reset (reset),
    .bus   (if_big)
  );

  gray_step_tracker #(.WIDTH(3), .CNT_W(2)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (if_small)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [2:0] gray;
    logic       clr;
    int         bin;
    int         dir;
    int         step;
    int         wrap;
    int         err;
    int         errc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic v, input logic [2:0] g,
                              input logic c, input int b, input int d,
                              input int s, input int w, input int e, input int ec);
    vec_t x;
    x.rst_n = r; x.valid = v; x.gray = g; x.clr = c;
    x.bin = b; x.dir = d; x.step = s; x.wrap = w; x.err = e; x.errc = ec;
    vecs.push_back(x);
  endfunction

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  function automatic logic [2:0] to_gray(input int b);
    logic [2:0] bb;
    bb = b[2:0];
    return bb ^ (bb >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 ns after the next rising edge
  task automatic apply(input logic r, input logic v, input logic [2:0] g, input logic c);
    @(negedge clk);
    reset             = r;
    if_big.valid_in   = v;
    if_big.gray_in    = g;
    if_big.clr_err    = c;
    if_small.valid_in = v;
    if_small.gray_in  = g;
    if_small.clr_err  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int i, input vec_t x);
    check($sformatf("v%0d bin_out", i),  int'(if_big.bin_out),  x.bin);
    check($sformatf("v%0d dir_up", i),   int'(if_big.dir_up),   x.dir);
    check($sformatf("v%0d step_cnt", i), int'(if_big.step_cnt), x.step);
    check($sformatf("v%0d wrap", i),     int'(if_big.wrap),     x.wrap);
    check($sformatf("v%0d err", i),      int'(if_big.err),      x.err);
    check($sformatf("v%0d err_cnt", i),  int'(if_big.err_cnt),  x.errc);
    check($sformatf("v%0d small step_cnt", i), int'(if_small.step_cnt), sat3(x.step));
    check($sformatf("v%0d small err_cnt", i),  int'(if_small.err_cnt),  sat3(x.errc));
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    reset             = 1'b0;
    if_big.valid_in   = 1'b0;
    if_big.gray_in    = 3'b000;
    if_big.clr_err    = 1'b0;
    if_small.valid_in = 1'b0;
    if_small.gray_in  = 3'b000;
    if_small.clr_err  = 1'b0;

    //   rst v  gray    clr bin dir step wrap err errc
    // Reset for two cycles, with junk on the inputs
    add(0, 1, 3'b110, 1,  0, 0, 0,  0, 0, 0);
    add(0, 1, 3'b011, 0,  0, 0, 0,  0, 0, 0);
    // Up sequence: first sample loads, then 8 legal up steps, wrap on 7->0
    add(1, 1, 3'b000, 0,  0, 0, 0,  0, 0, 0);
    add(1, 1, 3'b001, 0,  1, 1, 1,  0, 0, 0);
    add(1, 1, 3'b011, 0,  2, 1, 2,  0, 0, 0);
    add(1, 1, 3'b010, 0,  3, 1, 3,  0, 0, 0);
    add(1, 1, 3'b110, 0,  4, 1, 4,  0, 0, 0);
    add(1, 1, 3'b111, 0,  5, 1, 5,  0, 0, 0);
    add(1, 1, 3'b101, 0,  6, 1, 6,  0, 0, 0);
    add(1, 1, 3'b100, 0,  7, 1, 7,  0, 0, 0);
    add(1, 1, 3'b000, 0,  0, 1, 8,  1, 0, 0);
    // Down from 0: wrap on 0->7, then 7->6
    add(1, 1, 3'b100, 0,  7, 0, 9,  1, 0, 0);
    add(1, 1, 3'b101, 0,  6, 0, 10, 0, 0, 0);
    // Illegal jumps 6->0, 0->3 (single Gray bit flip), then legal 3->4
    add(1, 1, 3'b000, 0,  0, 0, 10, 0, 1, 1);
    add(1, 1, 3'b010, 0,  3, 0, 10, 0, 1, 2);
    add(1, 1, 3'b110, 0,  4, 1, 11, 0, 1, 2);
    // Stall three cycles, then valid_in low while gray changes
    add(1, 1, 3'b110, 0,  4, 1, 11, 0, 1, 2);
    add(1, 1, 3'b110, 0,  4, 1, 11, 0, 1, 2);
    add(1, 1, 3'b110, 0,  4, 1, 11, 0, 1, 2);
    add(1, 0, 3'b000, 0,  4, 1, 11, 0, 1, 2);
    add(1, 0, 3'b011, 0,  4, 1, 11, 0, 1, 2);
    // Clear alone, clear with illegal 4->0, clear with legal 0->1
    add(1, 0, 3'b011, 1,  4, 1, 11, 0, 0, 0);
    add(1, 1, 3'b000, 1,  0, 1, 11, 0, 1, 1);
    add(1, 1, 3'b001, 1,  1, 1, 12, 0, 0, 0);
    // Down 1->0 (no wrap), 0->7 (wrap)
    add(1, 1, 3'b000, 0,  0, 0, 13, 0, 0, 0);
    add(1, 1, 3'b100, 0,  7, 0, 14, 1, 0, 0);
    // Mid-sequence reset, then reload without a step or error
    add(0, 1, 3'b111, 0,  0, 0, 0,  0, 0, 0);
    add(1, 1, 3'b011, 0,  2, 0, 0,  0, 0, 0);
    add(1, 1, 3'b010, 0,  3, 1, 1,  0, 0, 0);
    // Five illegal jumps 3<->0 (2-bit err_cnt saturates at 3)
    add(1, 1, 3'b000, 0,  0, 1, 1,  0, 1, 1);
    add(1, 1, 3'b010, 0,  3, 1, 1,  0, 1, 2);
    add(1, 1, 3'b000, 0,  0, 1, 1,  0, 1, 3);
    add(1, 1, 3'b010, 0,  3, 1, 1,  0, 1, 4);
    add(1, 1, 3'b000, 0,  0, 1, 1,  0, 1, 5);
    // Legal up steps (2-bit step_cnt saturates at 3)
    add(1, 1, 3'b001, 0,  1, 1, 2,  0, 1, 5);
    add(1, 1, 3'b011, 0,  2, 1, 3,  0, 1, 5);
    add(1, 1, 3'b010, 0,  3, 1, 4,  0, 1, 5);
    add(1, 1, 3'b110, 0,  4, 1, 5,  0, 1, 5);

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].valid, vecs[i].gray, vecs[i].clr);
      check_vec(i, vecs[i]);
    end

    // Reset dominates a simultaneous clear and valid sample
    apply(1'b0, 1'b1, 3'b010, 1'b1);
    check("rst2 err", int'(if_big.err), 0);
    check("rst2 bin_out", int'(if_big.bin_out), 0);
    check("rst2 small step_cnt", int'(if_small.step_cnt), 0);

    // 8-bit step_cnt saturation: load 0, then 260 legal up steps
    apply(1'b1, 1'b1, 3'b000, 1'b0);
    for (int k = 1; k <= 260; k++) begin
      apply(1'b1, 1'b1, to_gray(k), 1'b0);
      if (k == 256) begin
        check("sat wrap at 7->0", int'(if_big.wrap), 1);
      end
    end
    check("sat step_cnt", int'(if_big.step_cnt), 255);
    check("sat small step_cnt", int'(if_small.step_cnt), 3);
    check("sat bin_out", int'(if_big.bin_out), 4);
    check("sat dir_up", int'(if_big.dir_up), 1);
    check("sat err", int'(if_big.err), 0);
    check("sat wrap idle", int'(if_big.wrap), 0);

    // Valid_in low clears the wrap pulse and holds everything
    apply(1'b1, 1'b1, to_gray(261), 1'b0);
    apply(1'b1, 1'b0, 3'b000, 1'b0);
    check("hold bin_out", int'(if_big.bin_out), 5);
    check("hold step_cnt", int'(if_big.step_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_step_tracker.md
Name: gray_step_tracker

Overview:
Downstream consumer of the 3-bit Gray up/down counter FSM. Each cycle it samples the counter's Gray outputs, converts them to binary and checks that the value moved by exactly ±1 (mod 2^WIDTH). It reports:
- current binary value and direction;
- a legal-step count;
- a wrap pulse;
- a sticky error flag and an error count for illegal transitions.

Used for on-board observation (LEDs/7-seg) and as a self-check on the counter.

Parameters:
WIDTH, 3, Gray/binary code width.
CNT_W, 8, width of step_cnt and err_cnt.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
valid_in  input  1  gray_in is sampled on this cycle when 1.
gray_in  input  WIDTH  Gray code from counter (MSB..LSB = O3,O2,O1).
clr_err  input  1  synchronous clear of err and err_cnt.
bin_out  output  WIDTH  binary equivalent of last accepted gray_in.
dir_up  output  1  1 = last legal step was +1, 0 = −1.
step_cnt  output  CNT_W  number of legal steps since reset; saturates at all-ones.
wrap  output  1  one-cycle pulse on legal max→0 (up) or 0→max (down) step.
err  output  1  sticky: illegal transition seen since reset/clr_err.
err_cnt  output  CNT_W  number of illegal transitions; saturates at all-ones.

Behaviour:
Reset (reset==0 at clk edge):
- All outputs = 0; internal prev_gray = 0; have_prev = 0.
- Reset dominates every other input, including mid-sequence.

Conversion:
- bin_new[WIDTH-1] = g[WIDTH-1]; bin_new[i] = bin_new[i+1] ^ g[i].
- Combinational from gray_in; all outputs are registered.
- Latency: outputs reflect a sample on the edge after valid_in/gray_in are presented (1 cycle).

valid_in == 0:
- All state holds; wrap = 0.

Internal state:
- IDLE (have_prev=0): first valid sample loads prev_gray and bin_out = bin_new.
  - No step, no error, dir_up unchanged, wrap = 0.
  - Go to TRACK.
- TRACK (have_prev=1): each valid sample compares bin_new with bin_prev = bin_out:
  - bin_new == bin_prev: stall. Nothing changes, wrap = 0.
  - bin_new == bin_prev+1 mod 2^WIDTH: legal up.
    - dir_up = 1; step_cnt += 1 (sat).
    - wrap = 1 iff bin_prev == 2^WIDTH−1.
  - bin_new == bin_prev−1 mod 2^WIDTH: legal down.
    - dir_up = 0; step_cnt += 1 (sat).
    - wrap = 1 iff bin_prev == 0.
  - Any other value (including single-bit Gray flips that are not ±1, e.g. 000→010): illegal.
    - err = 1; err_cnt += 1 (sat).
    - step_cnt and dir_up unchanged; wrap = 0.
    - Tracker resynchronises: bin_out/prev_gray load the new value.
- bin_out and prev_gray update on every valid sample in TRACK.

Other rules:
- clr_err == 1 without an illegal step that cycle: err = 0, err_cnt = 0.
- clr_err == 1 with a simultaneous illegal step: err = 1, err_cnt = 1 (new event wins).
- clr_err never affects bin_out, dir_up, step_cnt or wrap.
- Saturation: at all-ones, step_cnt/err_cnt hold; no wrap-around.
- WIDTH=2 is legal: ±1 remains distinct from other values.

Test Plan:
1. Up sequence: reset=0 for 2 cycles, then valid_in=1 with gray 000,001,011,010,110,111,101,100,000 (WIDTH=3) → bin_out 0..7 then 0; step_cnt=8; dir_up=1; wrap=1 only on the 100→000 cycle; err=0.
2. Down sequence from bin 0: gray 000,100,101 → bin 7 then 6; dir_up=0; wrap pulse on the 0→7 step; step_cnt=2.
3. Illegal jumps: TRACK at gray 000, apply 010 → err=1, err_cnt=1, bin_out=3, step_cnt unchanged. Then 110 (bin 4) → legal up, step_cnt+1.
4. Stall and valid gating: repeat the same gray for 3 cycles, then hold valid_in=0 while gray_in changes → no output change; wrap=0 throughout.
5. Clear timing: clr_err=1 alone → err=0, err_cnt=0. Then clr_err=1 on the same cycle as an illegal step → err=1, err_cnt=1.
6. Reset mid-sequence: assert reset=0 after 5 steps → all outputs 0. The next valid sample reloads without counting a step or an error. Set CNT_W=2 and drive 5 legal steps → step_cnt saturates at 3.
